// File: rtl/fpu_sequencer.sv
// fpu_sequencer: issue controller for the shared iterative FPU.
// Takes one legal FPU operation from decode, launches the FPU, waits for
// completion and returns the result through a write-back handshake to the
// float or integer register file. Only one operation is in flight at a time.
//
// Optional feature macro: FPU_SEQ_TIMEOUT_EN
//   defined   : WAIT is bounded by FPU_TIMEOUT cycles; an expired wait drops
//               the operation and sets the sticky TimeoutErr flag.
//   undefined : WAIT exits only on FpuDone; TimeoutErr is tied to 0.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   IssueValid, ALUControl   decoded FPU instruction and op code (0..9 legal)
//   FToI, Rd, SrcA, SrcB     target file select, destination, operands
//   Stall, Busy              front-end freeze, controller not idle
//   IllegalOp                one-cycle pulse for op codes 10..15
//   FpuStart, FpuOp,
//   FpuA, FpuB               FPU launch pulse and latched op/operands
//   FpuDone, FpuResult       FPU completion strobe and result
//   WbValid, WbReady         write-back handshake
//   WbFloat, WbInt, WbRd,
//   WbData                   write enables, address and data
//   TimeoutErr               sticky abort flag, cleared only by rst
module fpu_sequencer #(
  parameter int unsigned REG_NUM     = 32,
  parameter int unsigned FPU_TIMEOUT = 64,
  localparam int unsigned REG_SD_BIT_WIDTH = $clog2(REG_NUM)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        IssueValid,
  input  logic [3:0]                  ALUControl,
  input  logic                        FToI,
  input  logic [REG_SD_BIT_WIDTH-1:0] Rd,
  input  logic [31:0]                 SrcA,
  input  logic [31:0]                 SrcB,
  output logic                        Stall,
  output logic                        Busy,
  output logic                        IllegalOp,
  output logic                        FpuStart,
  output logic [3:0]                  FpuOp,
  output logic [31:0]                 FpuA,
  output logic [31:0]                 FpuB,
  input  logic                        FpuDone,
  input  logic [31:0]                 FpuResult,
  output logic                        WbValid,
  input  logic                        WbReady,
  output logic                        WbFloat,
  output logic                        WbInt,
  output logic [REG_SD_BIT_WIDTH-1:0] WbRd,
  output logic [31:0]                 WbData,
  output logic                        TimeoutErr
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT      = 2'd2,
    WRITEBACK = 2'd3
  } state_t;

  state_t                      state;
  logic                        legal_op;
  logic                        ftoi_q;
  logic [REG_SD_BIT_WIDTH-1:0] rd_q;

`ifdef FPU_SEQ_TIMEOUT_EN
  localparam int unsigned CNT_W = (FPU_TIMEOUT > 2) ? $clog2(FPU_TIMEOUT) : 1;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_err;
  assign TimeoutErr = timeout_err;
`else
  assign TimeoutErr = 1'b0;
`endif

  assign legal_op = (ALUControl <= 4'd9);

  // Decode must freeze in the very cycle a legal op is accepted.
  assign Stall = (state == IDLE) ? (IssueValid && legal_op) : 1'b1;
  assign Busy  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ftoi_q    <= 1'b0;
      rd_q      <= '0;
      IllegalOp <= 1'b0;
      FpuStart  <= 1'b0;
      FpuOp     <= '0;
      FpuA      <= '0;
      FpuB      <= '0;
      WbValid   <= 1'b0;
      WbFloat   <= 1'b0;
      WbInt     <= 1'b0;
      WbRd      <= '0;
      WbData    <= '0;
`ifdef FPU_SEQ_TIMEOUT_EN
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      IllegalOp <= 1'b0;
      FpuStart  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (IssueValid) begin
            if (legal_op) begin
              FpuOp    <= ALUControl;
              FpuA     <= SrcA;
              FpuB     <= SrcB;
              rd_q     <= Rd;
              ftoi_q   <= FToI;
              FpuStart <= 1'b1;
              state    <= ISSUE;
            end else begin
              IllegalOp <= 1'b1;
            end
          end
        end
        ISSUE: begin
`ifdef FPU_SEQ_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          if (FpuDone) begin
            WbData  <= FpuResult;
            WbRd    <= rd_q;
            WbValid <= 1'b1;
            WbFloat <= ~ftoi_q;
            // x0 is hard-wired zero: suppress the write, keep the handshake.
            WbInt   <= ftoi_q && (rd_q != '0);
            state   <= WRITEBACK;
          end
`ifdef FPU_SEQ_TIMEOUT_EN
          // Abort on the edge where the count would reach FPU_TIMEOUT-1.
          else if (wait_cnt == CNT_W'(FPU_TIMEOUT - 2)) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        WRITEBACK: begin
          if (WbReady) begin
            WbValid <= 1'b0;
            WbFloat <= 1'b0;
            WbInt   <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_sequencer.sv
// Self-checking bench for fpu_sequencer: table of operation vectors plus
// hand-written timeout and mid-operation reset sequences. Write-backs are
// checked against a queue of expected results filled when FpuDone is driven.
module tb_fpu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        IssueValid;
  logic [3:0]  ALUControl;
  logic        FToI;
  logic [4:0]  Rd;
  logic [31:0] SrcA, SrcB;
  logic        Stall, Busy, IllegalOp, FpuStart;
  logic [3:0]  FpuOp;
  logic [31:0] FpuA, FpuB;
  logic        FpuDone;
  logic [31:0] FpuResult;
  logic        WbValid, WbReady, WbFloat, WbInt;
  logic [4:0]  WbRd;
  logic [31:0] WbData;
  logic        TimeoutErr;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [3:0]  op;
    logic        ftoi;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int unsigned done_dly;
    int unsigned rdy_dly;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        fl;
    logic        in;
  } wb_t;

  vec_t vecs[7];
  wb_t  sb[$];

  fpu_sequencer #(.REG_NUM(32), .FPU_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .IssueValid(IssueValid), .ALUControl(ALUControl),
    .FToI(FToI), .Rd(Rd), .SrcA(SrcA), .SrcB(SrcB), .Stall(Stall),
    .Busy(Busy), .IllegalOp(IllegalOp), .FpuStart(FpuStart), .FpuOp(FpuOp),
    .FpuA(FpuA), .FpuB(FpuB), .FpuDone(FpuDone), .FpuResult(FpuResult),
    .WbValid(WbValid), .WbReady(WbReady), .WbFloat(WbFloat), .WbInt(WbInt),
    .WbRd(WbRd), .WbData(WbData), .TimeoutErr(TimeoutErr)
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every accepted write-back must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && WbValid && WbReady) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL sb_unexpected: got write-back rd=%0d data=%h expected none", WbRd, WbData);
      end else begin
        wb_t e;
        e = sb.pop_front();
        check32("sb_rd", 32'(WbRd), 32'(e.rd));
        check32("sb_data", WbData, e.data);
        check1("sb_float", WbFloat, e.fl);
        check1("sb_int", WbInt, e.in);
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input vec_t v);
    logic legal;
    logic exp_int;
    legal   = (v.op <= 4'd9);
    exp_int = v.ftoi && (v.rd != 5'd0);
    // cycle 0
    IssueValid = 1'b1; ALUControl = v.op; FToI = v.ftoi; Rd = v.rd;
    SrcA = v.a; SrcB = v.b;
    @(negedge clk);
    check1("stall_c0", Stall, legal);
    next();
    // cycle 1: scramble decode inputs to prove the operands were latched
    IssueValid = 1'b0; SrcA = $urandom; SrcB = $urandom;
    Rd = 5'($urandom); FToI = ~v.ftoi; ALUControl = 4'($urandom);
    @(negedge clk);
    if (!legal) begin
      check1("illegal_pulse", IllegalOp, 1'b1);
      check1("illegal_nostart", FpuStart, 1'b0);
      check1("illegal_stall", Stall, 1'b0);
      check1("illegal_busy", Busy, 1'b0);
      next();
      @(negedge clk);
      check1("illegal_once", IllegalOp, 1'b0);
      check1("illegal_nostart2", FpuStart, 1'b0);
      next();
      return;
    end
    check1("start_c1", FpuStart, 1'b1);
    check32("fpu_op", 32'(FpuOp), 32'(v.op));
    check32("fpu_a", FpuA, v.a);
    check32("fpu_b", FpuB, v.b);
    check1("stall_c1", Stall, 1'b1);
    next();
    for (int unsigned i = 0; i < v.done_dly; i++) begin
      @(negedge clk);
      check1("start_once", FpuStart, 1'b0);
      check1("wait_busy", Busy, 1'b1);
      check32("wait_a_stable", FpuA, v.a);
      next();
    end
    // completion cycle k
    FpuDone = 1'b1; FpuResult = v.res;
    sb.push_back('{rd: v.rd, data: v.res, fl: ~v.ftoi, in: exp_int});
    @(negedge clk);
    check1("wb_not_early", WbValid, 1'b0);
    next();
    FpuDone = 1'b0; FpuResult = $urandom;
    for (int unsigned i = 0; i <= v.rdy_dly; i++) begin
      WbReady = (i == v.rdy_dly);
      @(negedge clk);
      check1("wb_valid", WbValid, 1'b1);
      check32("wb_data", WbData, v.res);
      check32("wb_rd", 32'(WbRd), 32'(v.rd));
      check1("wb_float", WbFloat, ~v.ftoi);
      check1("wb_int", WbInt, exp_int);
      next();
    end
    WbReady = 1'b0;
    @(negedge clk);
    check1("idle_stall", Stall, 1'b0);
    check1("idle_busy", Busy, 1'b0);
    check1("idle_wbvalid", WbValid, 1'b0);
    next();
  endtask

  task automatic check_all_zero(input string tag);
    check1({tag, "_stall"}, Stall, 1'b0);
    check1({tag, "_busy"}, Busy, 1'b0);
    check1({tag, "_illegal"}, IllegalOp, 1'b0);
    check1({tag, "_start"}, FpuStart, 1'b0);
    check32({tag, "_op"}, 32'(FpuOp), 32'd0);
    check32({tag, "_a"}, FpuA, 32'd0);
    check32({tag, "_b"}, FpuB, 32'd0);
    check1({tag, "_wbvalid"}, WbValid, 1'b0);
    check1({tag, "_wbfloat"}, WbFloat, 1'b0);
    check1({tag, "_wbint"}, WbInt, 1'b0);
    check32({tag, "_wbrd"}, 32'(WbRd), 32'd0);
    check32({tag, "_wbdata"}, WbData, 32'd0);
    check1({tag, "_terr"}, TimeoutErr, 1'b0);
  endtask

  initial begin
    vecs[0] = '{4'd0, 1'b0, 5'd3,  32'h3F800000, 32'h40000000, 32'h40400000, 2, 0};
    vecs[1] = '{4'd7, 1'b1, 5'd5,  32'h40400000, 32'h00000000, 32'h00000003, 3, 3};
    vecs[2] = '{4'd7, 1'b1, 5'd0,  32'h40A00000, 32'h00000000, 32'h00000005, 1, 0};
    vecs[3] = '{4'd12, 1'b0, 5'd4, 32'h11111111, 32'h22222222, 32'h0, 0, 0};
    vecs[4] = '{4'd9, 1'b0, 5'd31, 32'hC0000000, 32'h3F000000, 32'hBF800000, 0, 1};
    vecs[5] = '{4'd15, 1'b1, 5'd6, 32'h33333333, 32'h44444444, 32'h0, 0, 0};
    vecs[6] = '{4'd3, 1'b1, 5'd17, 32'h41200000, 32'h40000000, 32'h00000014, 5, 0};

    rst = 1'b1; IssueValid = 1'b0; ALUControl = '0; FToI = 1'b0; Rd = '0;
    SrcA = '0; SrcB = '0; FpuDone = 1'b0; FpuResult = '0; WbReady = 1'b0;
    next();
    next();
    @(negedge clk);
    check_all_zero("reset");
    next();
    rst = 1'b0;
    next();

    for (int i = 0; i < 7; i++) run_op(vecs[i]);

    // Timeout: FpuDone never arrives.
    IssueValid = 1'b1; ALUControl = 4'd1; FToI = 1'b0; Rd = 5'd2;
    SrcA = 32'h12345678; SrcB = 32'h9ABCDEF0;
    next();
    IssueValid = 1'b0;
    @(negedge clk);
    check1("to_start", FpuStart, 1'b1);
    next();
`ifdef FPU_SEQ_TIMEOUT_EN
    for (int c = 2; c <= 8; c++) begin
      @(negedge clk);
      check1("to_busy", Busy, 1'b1);
      check1("to_terr_early", TimeoutErr, 1'b0);
      next();
    end
    @(negedge clk);
    check1("to_terr", TimeoutErr, 1'b1);
    check1("to_idle", Busy, 1'b0);
    check1("to_nowb", WbValid, 1'b0);
    check1("to_stall", Stall, 1'b0);
    next();
`else
    for (int c = 2; c <= 12; c++) begin
      @(negedge clk);
      check1("nto_busy", Busy, 1'b1);
      check1("nto_terr", TimeoutErr, 1'b0);
      next();
    end
    FpuDone = 1'b1; FpuResult = 32'h0BADF00D;
    sb.push_back('{rd: 5'd2, data: 32'h0BADF00D, fl: 1'b1, in: 1'b0});
    next();
    FpuDone = 1'b0; WbReady = 1'b1;
    @(negedge clk);
    check1("nto_wbvalid", WbValid, 1'b1);
    next();
    WbReady = 1'b0;
    @(negedge clk);
    check1("nto_idle", Busy, 1'b0);
    next();
`endif
    run_op(vecs[0]);
    @(negedge clk);
`ifdef FPU_SEQ_TIMEOUT_EN
    check1("terr_sticky", TimeoutErr, 1'b1);
`else
    check1("terr_tied", TimeoutErr, 1'b0);
`endif
    next();

    // Reset in WAIT, then a spurious FpuDone.
    IssueValid = 1'b1; ALUControl = 4'd2; FToI = 1'b0; Rd = 5'd9;
    SrcA = 32'hAAAA5555; SrcB = 32'h5555AAAA;
    next();
    IssueValid = 1'b0;
    next();
    next();
    rst = 1'b1;
    next();
    rst = 1'b0; FpuDone = 1'b1; FpuResult = 32'hDEADBEEF;
    @(negedge clk);
    check_all_zero("midrst");
    next();
    FpuDone = 1'b0;
    @(negedge clk);
    check1("midrst_nowb", WbValid, 1'b0);
    check1("midrst_idle", Busy, 1'b0);
    next();

    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_empty: got %0d pending write-backs expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
